orbit_trail_plotter: RTL and testbench

Downstream consumer of the orbital integrator's `X`/`Y` position stream. It decimates the per-step position samples and converts each kept sample from metres to screen pixels, clipping points that fall off screen. Each kept point is written as one pixel into the 8-bit VGA framebuffer over a valid/ready write port. A ring of the last `TRAIL_LEN` plotted addresses is kept so the oldest trail pixel is erased back to background before each new one is drawn.

---
 rtl/orbit_pkg.sv | 22 ++
 rtl/orbit_trail_plotter_if.sv | 13 +
 rtl/orbit_trail_fifo.sv | 68 ++++++
 rtl/orbit_trail_plotter.sv | 150 +++++++++++++++
 tb/tb_orbit_trail_plotter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/orbit_pkg.sv
// rtl/orbit_pkg.sv - shared screen geometry, framebuffer types and plotter FSM states
package orbit_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int FB_ADDR_W = 19;

  typedef logic [7:0]           pixel_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ERASE,
    DRAW
  } state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/orbit_trail_plotter_if.sv
// rtl/orbit_trail_plotter_if.sv - framebuffer pixel write port (valid/ready)
interface orbit_trail_plotter_if;
  import orbit_pkg::*;

  logic     wr_valid;
  logic     wr_ready;
  fb_addr_t wr_addr;
  pixel_t   wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/orbit_trail_fifo.sv
// rtl/orbit_trail_fifo.sv - ring of recently plotted pixel addresses, oldest readable combinationally
module orbit_trail_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (PW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[head_q];

  // A push into a full ring is only legal when the oldest entry leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_pop) begin
      head_d = (head_q == PLAST) ? '0 : head_q + 1'b1;
    end
    if (do_push) begin
      tail_d = (tail_q == PLAST) ? '0 : tail_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[tail_q] <= wr_data;
    end
  end

endmodule

// File: rtl/orbit_trail_plotter.sv
// rtl/orbit_trail_plotter.sv - decimate orbit positions, map metres to pixels, draw a fading trail
module orbit_trail_plotter #(
  parameter int         SHIFT       = 15,
  parameter int         DECIM       = 1024,
  parameter int         TRAIL_LEN   = 64,
  parameter logic [7:0] COLOR_ORBIT = 8'hFF,
  parameter logic [7:0] COLOR_BG    = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [31:0]  X,
  input  logic signed [31:0]  Y,
  orbit_trail_plotter_if.master wr,
  output logic                busy,
  output logic [15:0]         drop_cnt,
  output logic [15:0]         clip_cnt
);
  import orbit_pkg::*;

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DECIM - 1);

  state_e             state_q, state_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic signed [31:0] x_q, y_q;
  fb_addr_t           new_addr_q, new_addr_d;
  fb_addr_t           addr_q, addr_d;
  pixel_t             data_q, data_d;
  logic [15:0]        drop_q, drop_d;
  logic [15:0]        clip_q, clip_d;

  logic               keep;
  logic signed [31:0] px_s, py_s;
  logic               on_screen;
  fb_addr_t           calc_addr;
  fb_addr_t           oldest_addr;
  logic               trail_full, trail_empty;
  logic               trail_push, trail_pop;

  assign keep   = in_valid && (dcnt_q == DLAST);
  assign dcnt_d = in_valid ? ((dcnt_q == DLAST) ? '0 : dcnt_q + 1'b1) : dcnt_q;

  // Arithmetic shift of signed values floors toward minus infinity, so -0.3 px lands on -1.
  assign px_s      = (x_q >>> SHIFT) + 32'(SCREEN_W / 2);
  assign py_s      = 32'(SCREEN_H / 2) - (y_q >>> SHIFT);
  assign on_screen = (px_s >= 0) && (px_s < SCREEN_W) && (py_s >= 0) && (py_s < SCREEN_H);
  assign calc_addr = fb_addr_t'(py_s) * fb_addr_t'(SCREEN_W) + fb_addr_t'(px_s);

  assign trail_pop  = (state_q == ERASE) && wr.wr_ready && !trail_empty;
  assign trail_push = (state_q == DRAW) && wr.wr_ready;

  orbit_trail_fifo #(
    .DEPTH (TRAIL_LEN),
    .W     (FB_ADDR_W)
  ) u_trail (
    .clk     (clk),
    .rst     (rst),
    .push    (trail_push),
    .pop     (trail_pop),
    .wr_data (new_addr_q),
    .rd_data (oldest_addr),
    .full    (trail_full),
    .empty   (trail_empty)
  );

  always_comb begin
    state_d    = state_q;
    new_addr_d = new_addr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    drop_d     = drop_q;
    clip_d     = clip_q;
    case (state_q)
      IDLE: begin
        if (keep) begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (!on_screen) begin
          clip_d  = sat_inc(clip_q);
          state_d = IDLE;
        end else begin
          new_addr_d = calc_addr;
          if (trail_full) begin
            state_d = ERASE;
            addr_d  = oldest_addr;
            data_d  = COLOR_BG;
          end else begin
            state_d = DRAW;
            addr_d  = calc_addr;
            data_d  = COLOR_ORBIT;
          end
        end
      end
      ERASE: begin
        if (wr.wr_ready) begin
          state_d = DRAW;
          addr_d  = new_addr_q;
          data_d  = COLOR_ORBIT;
        end
      end
      DRAW: begin
        if (wr.wr_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Acceptance needs IDLE at the sampling edge, so a sample landing on the return cycle is lost.
    if (keep && (state_q != IDLE)) begin
      drop_d = sat_inc(drop_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dcnt_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      new_addr_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      drop_q     <= '0;
      clip_q     <= '0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      new_addr_q <= new_addr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      drop_q     <= drop_d;
      clip_q     <= clip_d;
      if (keep && (state_q == IDLE)) begin
        x_q <= X;
        y_q <= Y;
      end
    end
  end

  assign wr.wr_valid = (state_q == ERASE) || (state_q == DRAW);
  assign wr.wr_addr  = addr_q;
  assign wr.wr_data  = data_q;
  assign busy        = (state_q != IDLE);
  assign drop_cnt    = drop_q;
  assign clip_cnt    = clip_q;

endmodule

// File: tb/tb_orbit_trail_plotter.sv
// tb/tb_orbit_trail_plotter.sv - scoreboard bench for orbit_trail_plotter
module tb_orbit_trail_plotter;
  import orbit_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [31:0] x_in = '0;
  logic signed [31:0] y_in = '0;
  logic               busy;
  logic [15:0]        drop_cnt, clip_cnt;

  logic               in_valid2 = 1'b0;
  logic signed [31:0] x2 = '0;
  logic signed [31:0] y2 = '0;
  logic               busy2;
  logic [15:0]        drop2, clip2;

  int n_cmp = 0;
  int n_err = 0;
  logic [26:0] exp_q[$];
  logic [26:0] exp2_q[$];

  always #5 clk = ~clk;

  orbit_trail_plotter_if fb();
  orbit_trail_plotter_if fb2();

  orbit_trail_plotter #(
    .SHIFT(15), .DECIM(1), .TRAIL_LEN(4), .COLOR_ORBIT(8'hFF), .COLOR_BG(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .X(x_in), .Y(y_in), .wr(fb.master),
    .busy(busy), .drop_cnt(drop_cnt), .clip_cnt(clip_cnt)
  );

  orbit_trail_plotter #(
    .SHIFT(15), .DECIM(4), .TRAIL_LEN(4), .COLOR_ORBIT(8'hFF), .COLOR_BG(8'h00)
  ) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .X(x2), .Y(y2), .wr(fb2.master),
    .busy(busy2), .drop_cnt(drop2), .clip_cnt(clip2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && fb.wr_valid && fb.wr_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected none", fb.wr_addr, fb.wr_data);
      end else begin
        logic [26:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(fb.wr_addr), 32'(e[26:8]));
        check("wr_data", 32'(fb.wr_data), 32'(e[7:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && fb2.wr_valid && fb2.wr_ready) begin
      if (exp2_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write2: got addr %0d data %0d expected none", fb2.wr_addr, fb2.wr_data);
      end else begin
        logic [26:0] e;
        e = exp2_q.pop_front();
        check("wr_addr2", 32'(fb2.wr_addr), 32'(e[26:8]));
        check("wr_data2", 32'(fb2.wr_data), 32'(e[7:0]));
      end
    end
  end

  // Cycle index 1 is the cycle after the sampling edge; first write expected at 2.
  task automatic run_point(input int x, input int y, input int exp_first, input int exp_idle,
                           input string tag);
    int first;
    int idle;
    x_in = x;
    y_in = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    first = -1;
    idle = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (fb.wr_valid && first < 0) first = n;
      if (!busy) begin
        idle = n;
        break;
      end
    end
    tick();
    check({tag, "_first_valid"}, first, exp_first);
    check({tag, "_idle_cycle"}, idle, exp_idle);
  endtask

  task automatic wait_valid(input string tag);
    int seen;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (fb.wr_valid) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_wr_valid_seen"}, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [18:0] cap_addr;
    logic [7:0]  cap_data;
    int          idle_seen;

    fb.wr_ready  = 1'b1;
    fb2.wr_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_wr_valid", fb.wr_valid, 0);
    check("rst_wr_addr", fb.wr_addr, 0);
    check("rst_wr_data", fb.wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_clip_cnt", clip_cnt, 0);
    rst = 1'b0;
    tick();

    exp_q.push_back({19'd154126, 8'hFF});
    run_point(6771000, 0, 2, 3, "A");
    exp_q.push_back({19'd22080, 8'hFF});
    run_point(0, 6771000, 2, 3, "B");
    exp_q.push_back({19'd153713, 8'hFF});
    run_point(-6771000, 0, 2, 3, "C");
    run_point(20000000, 0, -1, 2, "clip_far");
    check("clip_cnt_1", clip_cnt, 1);
    exp_q.push_back({19'd286400, 8'hFF});
    run_point(0, -6771000, 2, 3, "D");
    exp_q.push_back({19'd154126, 8'h00});
    exp_q.push_back({19'd147530, 8'hFF});
    run_point(327680, 327680, 2, 4, "E");
    exp_q.push_back({19'd22080, 8'h00});
    exp_q.push_back({19'd0, 8'hFF});
    run_point(-10485760, 7864320, 2, 4, "F_corner0");
    run_point(10485760, 0, -1, 2, "clip_px640");
    run_point(0, 7897088, -1, 2, "clip_pyneg");
    check("clip_cnt_3", clip_cnt, 3);
    exp_q.push_back({19'd153713, 8'h00});
    exp_q.push_back({19'd307199, 8'hFF});
    run_point(10452992, -7831552, 2, 4, "G_cornermax");
    check("drop_cnt_0", drop_cnt, 0);

    // Stalled erase of oldest entry (D), then reset while it is pending.
    fb.wr_ready = 1'b0;
    x_in = 6771000;
    y_in = 0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("H");
    check("H_erase_addr", fb.wr_addr, 286400);
    check("H_erase_data", fb.wr_data, 0);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_wr_valid", fb.wr_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_clip_cnt", clip_cnt, 0);
    check("mid_rst_drop_cnt", drop_cnt, 0);
    check("mid_rst_wr_addr", fb.wr_addr, 0);
    rst = 1'b0;
    tick();

    // First point after reset draws directly; stall it and count drops.
    exp_q.push_back({19'd22080, 8'hFF});
    x_in = 0;
    y_in = 6771000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("I");
    check("I_draw_data", fb.wr_data, 8'hFF);
    check("I_draw_addr", fb.wr_addr, 22080);
    cap_addr = fb.wr_addr;
    cap_data = fb.wr_data;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      in_valid = (k % 2 == 0);
      x_in = 32'(k * 1000);
      @(negedge clk);
      check("stall_hold", {fb.wr_valid, 4'd0, cap_addr, cap_data},
            {1'b1, 4'd0, fb.wr_addr, fb.wr_data} & {1'b1, 4'd0, 19'h7FFFF, 8'hFF});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fb.wr_ready = 1'b1;
    idle_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!busy) begin
        idle_seen = 1;
        break;
      end
    end
    check("I_idle_seen", idle_seen, 1);
    check("drop_cnt_5", drop_cnt, 5);
    tick();

    exp_q.push_back({19'd147530, 8'hFF});
    run_point(327680, 327680, 2, 3, "J_after_rst");

    // Decimate by 4: samples 4 and 8 are the kept ones.
    exp2_q.push_back({19'd153924, 8'hFF});
    exp2_q.push_back({19'd153928, 8'hFF});
    for (int k = 1; k <= 8; k++) begin
      x2 = 32'(k * 32768);
      in_valid2 = 1'b1;
      tick();
    end
    in_valid2 = 1'b0;
    repeat (6) tick();
    check("decim_drop_cnt", drop2, 0);
    check("decim_busy", busy2, 0);

    repeat (2) tick();
    check("queue_empty", exp_q.size(), 0);
    check("queue2_empty", exp2_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
